// File: rtl/store_issue_queue.sv
//==============================================================================
// Module      : store_issue_queue
// Description : In-order store/AMO request FIFO in front of the store unit,
//               with a zero-latency bypass when empty.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package config_pkg;
    typedef struct packed {
        int unsigned XLEN;
        int unsigned VLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;

    typedef struct packed {
        logic        valid;
        logic [63:0] vaddr;
        logic        overflow;
        logic [63:0] data;
        logic [7:0]  be;
        logic [7:0]  operation;
        logic [3:0]  trans_id;
    } lsu_ctrl_t;
endpackage

module store_issue_queue #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg    = config_pkg::cva6_cfg_empty,
    parameter type                   lsu_ctrl_t = config_pkg::lsu_ctrl_t,
    parameter int unsigned           DEPTH      = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     valid_i,
    input  lsu_ctrl_t                lsu_ctrl_i,
    output logic                     ready_o,
    output logic                     valid_o,
    output lsu_ctrl_t                lsu_ctrl_o,
    input  logic                     pop_i,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   usage_o
);

    localparam int unsigned          c_ptr_w = $clog2(DEPTH);
    localparam int unsigned          c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0]   c_depth = DEPTH[c_cnt_w-1:0];

    lsu_ctrl_t            r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_cnt_w-1:0]   r_count;

    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_write;
    logic w_advance_rd;
    logic w_unused_cfg;

    // Configuration only types the instance; nothing here depends on it.
    assign w_unused_cfg = ^CVA6Cfg;

    assign w_empty = (r_count == '0);
    assign ready_o = (r_count != c_depth);
    assign empty_o = w_empty;
    assign usage_o = r_count;

    assign valid_o    = w_empty ? (valid_i & ~flush_i) : ~flush_i;
    assign lsu_ctrl_o = w_empty ? lsu_ctrl_i : r_mem[r_rd_ptr];

    assign w_push = valid_i & ready_o & ~flush_i;
    assign w_pop  = pop_i & valid_o;

    // A request consumed straight through the bypass is never stored.
    assign w_write      = w_push & ~(w_empty & w_pop);
    assign w_advance_rd = w_pop & ~w_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_advance_rd) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_write && !w_advance_rd) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (!w_write && w_advance_rd) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

    // Storage needs no reset: entries are only read once counted.
    always_ff @(posedge clk_i) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= lsu_ctrl_i;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_store_issue_queue.sv
//==============================================================================
// Module      : tb_store_issue_queue
// Description : Directed plus random checks of store_issue_queue against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_store_issue_queue;
    import config_pkg::*;

    localparam int DEPTH = 2;

    logic                    clk_i;
    logic                    rst_ni;
    logic                    flush_i;
    logic                    valid_i;
    lsu_ctrl_t               lsu_ctrl_i;
    logic                    ready_o;
    logic                    valid_o;
    lsu_ctrl_t               lsu_ctrl_o;
    logic                    pop_i;
    logic                    empty_o;
    logic [$clog2(DEPTH):0]  usage_o;

    int n_total = 0;
    int n_pass  = 0;

    lsu_ctrl_t q[$];

    store_issue_queue #(
        .CVA6Cfg    (cva6_cfg_empty),
        .lsu_ctrl_t (lsu_ctrl_t),
        .DEPTH      (DEPTH)
    ) u_dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .valid_i    (valid_i),
        .lsu_ctrl_i (lsu_ctrl_i),
        .ready_o    (ready_o),
        .valid_o    (valid_o),
        .lsu_ctrl_o (lsu_ctrl_o),
        .pop_i      (pop_i),
        .empty_o    (empty_o),
        .usage_o    (usage_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_pl(input string tag, input lsu_ctrl_t obs, input lsu_ctrl_t exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed vaddr=%0h tid=%0h data=%0h expected vaddr=%0h tid=%0h data=%0h",
                    tag, obs.vaddr, obs.trans_id, obs.data, exp.vaddr, exp.trans_id, exp.data);
    endtask

    function automatic lsu_ctrl_t mk(input logic [63:0] va, input logic [3:0] tid);
        lsu_ctrl_t r;
        r           = '0;
        r.valid     = 1'b1;
        r.vaddr     = va;
        r.data      = {$urandom, $urandom};
        r.be        = 8'($urandom);
        r.operation = 8'($urandom);
        r.trans_id  = tid;
        return r;
    endfunction

    // Drive one cycle starting at posedge+1, check mid-cycle, update the model at the edge.
    task automatic step(input logic v, input lsu_ctrl_t c, input logic p, input logic f,
                        output logic ov, output lsu_ctrl_t oc);
        logic      ev;
        logic      push;
        logic      pop;
        lsu_ctrl_t eh;
        int        n;
        valid_i    = v;
        lsu_ctrl_i = c;
        pop_i      = p;
        flush_i    = f;
        #2;
        n  = q.size();
        ev = f ? 1'b0 : ((n == 0) ? v : 1'b1);
        eh = (n == 0) ? c : q[0];
        chk("ready", 64'(ready_o), 64'(n != DEPTH));
        chk("valid", 64'(valid_o), 64'(ev));
        chk("usage", 64'(usage_o), 64'(n));
        chk("empty", 64'(empty_o), 64'(n == 0));
        if (ev) chk_pl("head", lsu_ctrl_o, eh);
        ov   = valid_o;
        oc   = lsu_ctrl_o;
        push = v && (n != DEPTH) && !f;
        pop  = p && ev;
        @(posedge clk_i);
        if (f) begin
            q.delete();
        end else begin
            if (pop && n > 0) void'(q.pop_front());
            if (push && !(n == 0 && pop)) q.push_back(c);
        end
        #1;
    endtask

    initial begin
        logic      ov;
        lsu_ctrl_t oc;
        lsu_ctrl_t a;
        lsu_ctrl_t idle;

        idle       = '0;
        rst_ni     = 1'b0;
        flush_i    = 1'b0;
        pop_i      = 1'b0;
        valid_i    = 1'b1;
        a          = mk(64'h55, 4'd1);
        lsu_ctrl_i = a;
        #3;
        chk("rst_ready", 64'(ready_o), 64'd1);
        chk("rst_empty", 64'(empty_o), 64'd1);
        chk("rst_usage", 64'(usage_o), 64'd0);
        chk("rst_bypass_valid", 64'(valid_o), 64'd1);
        chk_pl("rst_bypass_payload", lsu_ctrl_o, a);
        valid_i    = 1'b0;
        lsu_ctrl_i = idle;
        #9 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Bypass consumed in the same cycle
        step(1'b1, mk(64'h1000, 4'd0), 1'b1, 1'b0, ov, oc);
        chk("bypass_valid", 64'(ov), 64'd1);
        chk("bypass_vaddr", oc.vaddr, 64'h1000);
        #1 chk("bypass_usage", 64'(usage_o), 64'd0);

        // Stall hold, then full refusal
        step(1'b1, mk(64'h2000, 4'd1), 1'b0, 1'b0, ov, oc);
        step(1'b1, mk(64'h3000, 4'd2), 1'b0, 1'b0, ov, oc);
        chk("hold_vaddr", oc.vaddr, 64'h2000);
        #1;
        chk("full_usage", 64'(usage_o), 64'd2);
        chk("full_ready", 64'(ready_o), 64'd0);
        step(1'b1, mk(64'h4000, 4'd3), 1'b1, 1'b0, ov, oc);
        chk("full_pop_vaddr", oc.vaddr, 64'h2000);
        #1;
        chk("after_full_usage", 64'(usage_o), 64'd1);
        chk("after_full_ready", 64'(ready_o), 64'd1);
        chk("after_full_head", lsu_ctrl_o.vaddr, 64'h3000);
        step(1'b0, idle, 1'b1, 1'b0, ov, oc);

        // Pointer wrap with occupancy held at one
        step(1'b1, mk(64'h8000, 4'd0), 1'b0, 1'b0, ov, oc);
        for (int i = 1; i < 10; i++) begin
            step(1'b1, mk(64'h8000 + 64'(i), 4'(i)), 1'b1, 1'b0, ov, oc);
            chk("wrap_order", 64'(oc.trans_id), 64'(i - 1));
            #1 chk("wrap_usage", 64'(usage_o), 64'd1);
        end
        step(1'b0, idle, 1'b1, 1'b0, ov, oc);
        chk("wrap_last", 64'(oc.trans_id), 64'd9);

        // Flush drops everything, including the flush-cycle request
        step(1'b1, mk(64'hA000, 4'd4), 1'b0, 1'b0, ov, oc);
        step(1'b1, mk(64'hB000, 4'd5), 1'b0, 1'b0, ov, oc);
        step(1'b1, mk(64'hC000, 4'd6), 1'b0, 1'b1, ov, oc);
        chk("flush_valid", 64'(ov), 64'd0);
        #1;
        chk("flush_empty", 64'(empty_o), 64'd1);
        chk("flush_usage", 64'(usage_o), 64'd0);
        step(1'b0, idle, 1'b0, 1'b0, ov, oc);
        chk("flush_absent", 64'(ov), 64'd0);

        // Asynchronous reset mid-operation
        step(1'b1, mk(64'hD000, 4'd7), 1'b0, 1'b0, ov, oc);
        step(1'b1, mk(64'hE000, 4'd8), 1'b0, 1'b0, ov, oc);
        valid_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_usage", 64'(usage_o), 64'd0);
        chk("arst_ready", 64'(ready_o), 64'd1);
        chk("arst_empty", 64'(empty_o), 64'd1);
        q.delete();
        #2 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, mk({$urandom, $urandom}, 4'(i)),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0, ov, oc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
